// File: rtl/elapsed_time_meter_pkg.sv
// Shared types and constants for the elapsed-time meter.
package elapsed_time_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 4;
  localparam int MAX_MS_DEF = 9999;

  // Add one to a packed BCD value; each digit rolls 9->0 and carries upward.
  function automatic logic [NUM_DIGITS*BCD_W-1:0] bcd_inc(
    input logic [NUM_DIGITS*BCD_W-1:0] v
  );
    logic [NUM_DIGITS*BCD_W-1:0] r;
    logic                        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (carry) begin
        if (v[d*BCD_W +: BCD_W] == 4'd9) begin
          r[d*BCD_W +: BCD_W] = '0;
        end else begin
          r[d*BCD_W +: BCD_W] = v[d*BCD_W +: BCD_W] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/elapsed_time_meter_tick_gen_ms.sv
// Millisecond prescaler: counts 0..TICKS_PER_MS-1 while enabled and flags
// the last count of each millisecond.
module tick_gen_ms #(
  parameter int TICKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICKS_PER_MS - 1);

  logic [15:0] cnt;

  // tick is high for the whole cycle in which the counter sits at LAST,
  // so the consumer acts on the same edge at which the counter wraps.
  assign tick = en && (cnt == LAST);

  // Prescaler counter; a sync clear wins over counting.
  always_ff @(posedge clk) begin
    if (rst || sync_clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 16'd1;
    end
  end

endmodule

// File: rtl/elapsed_time_meter.sv
// Measures start-to-stop interval in whole milliseconds with a saturating
// 4-digit BCD counter and a parallel binary copy.
module elapsed_time_meter
  import elapsed_time_meter_pkg::*;
#(
  parameter int TICKS_PER_MS = 50000,
  parameter int MAX_MS       = MAX_MS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic [15:0] elapsed_bcd,
  output logic [13:0] elapsed_bin,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam logic [13:0] LAST_BIN = 14'(MAX_MS - 1);

  state_t state;
  logic   tick;
  logic   start_ok;

  // start is only honoured outside RUN; re-arming needs a stop first.
  assign start_ok = start && (state != RUN);

  tick_gen_ms #(
    .TICKS_PER_MS(TICKS_PER_MS)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (state == RUN),
    .sync_clr(clear || start_ok),
    .tick    (tick)
  );

  // Control FSM and counters: rst > clear > stop/tick in RUN > start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      elapsed_bcd <= '0;
      elapsed_bin <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else if (clear) begin
      // Abandons any measurement without a done pulse.
      state       <= IDLE;
      elapsed_bcd <= '0;
      elapsed_bin <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          // A tick coinciding with stop is still counted in the held value.
          if (tick) begin
            elapsed_bcd <= bcd_inc(elapsed_bcd);
            elapsed_bin <= elapsed_bin + 14'd1;
            if (elapsed_bin == LAST_BIN) begin
              overflow <= 1'b1;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= HOLD;
            end
          end
          if (stop) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= HOLD;
          end
        end
        default: begin
          // IDLE and HOLD: stop is ignored, start begins a fresh run.
          if (start) begin
            state       <= RUN;
            elapsed_bcd <= '0;
            elapsed_bin <= '0;
            busy        <= 1'b1;
            overflow    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/elapsed_time_meter.md
Name: elapsed_time_meter

Overview:
Measures the interval between a start event and a stop event in whole milliseconds. It is the measuring counterpart of the fixed-interval timeout timers: those assert a timeout after a known time, while this block reports an unknown elapsed time. A 1 ms prescaler drives a saturating 4-digit BCD millisecond counter. Results feed the seven-segment display path and the lab control FSMs (reaction-time and response-window checks).

Parameters:
TICKS_PER_MS, 50000, clk cycles per millisecond (50 MHz board clock); legal range 2..65535
MAX_MS, 9999, saturation value in ms; must be ≤ 9999 so it fits 4 BCD digits

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; begin a measurement from zero
stop  input  1  single-cycle pulse; end the measurement
clear  input  1  return to idle and zero the result
elapsed_bcd  output  16  four BCD digits, [15:12] = thousands … [3:0] = units
elapsed_bin  output  14  same value in binary
busy  output  1  high while measuring
done  output  1  one-cycle pulse when a measurement ends (by stop or by saturation)
overflow  output  1  sticky; set when MAX_MS is reached, cleared by start, clear or rst

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset (rst=1 at a clk edge): state=IDLE, prescaler=0, elapsed_bcd=0, elapsed_bin=0, busy=0, done=0, overflow=0.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - start → RUN; prescaler and counters zeroed; overflow cleared.
  - stop is ignored.
- RUN:
  - busy=1.
  - Prescaler counts 0..TICKS_PER_MS-1 and wraps.
  - tick is high in the cycle the prescaler is at TICKS_PER_MS-1.
  - On tick, elapsed increments by 1. BCD digits carry 9→0 into the next digit; binary is incremented in parallel.
  - The first increment occurs exactly TICKS_PER_MS cycles after the start edge.
- Saturation: if a tick would take elapsed from MAX_MS-1 to MAX_MS:
  - elapsed=MAX_MS, overflow=1, done pulses on the next cycle, state → HOLD.
  - Elapsed never exceeds MAX_MS and never wraps.
- stop in RUN → HOLD; busy drops on the next cycle; done=1 for exactly one cycle, the cycle after stop is sampled.
- stop and tick in the same cycle: the tick's increment is applied, and the held value includes it.
- HOLD:
  - busy=0; elapsed is frozen.
  - stop is ignored.
  - start restarts, exactly as from IDLE.
- Priority within one cycle: rst > clear > stop (in RUN) > start.
  - In RUN, start is ignored; re-arming requires stop first.
  - In IDLE/HOLD, start together with stop → start wins.
- clear (any state) → IDLE, prescaler and counters zeroed, overflow=0, done=0, busy=0.
- rst or clear mid-measurement: the measurement is abandoned and no done pulse is produced.
- Outputs are registered; elapsed_bcd and elapsed_bin always agree in value.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, HOLD=2'd2), BCD digit width (4), MAX_MS default.
- Sub-module tick_gen_ms: prescaler with inputs clk, rst, en, sync_clr and output tick (1-cycle pulse); parameter TICKS_PER_MS; 16-bit counter.
- The BCD cascade and the FSM live in the top-level elapsed_time_meter.

Test Plan (bench uses TICKS_PER_MS=4):
- rst held 2 cycles, then released → all outputs 0, busy=0; stop pulses in IDLE → no change.
- start at cycle 0, stop at cycle 4×37 → elapsed_bin=37, elapsed_bcd=16'h0037, done high exactly 1 cycle, busy low afterwards, overflow=0.
- BCD carry: run through 99 → 100 and 999 → 1000 → elapsed_bcd goes 16'h0099 → 16'h0100 and 16'h0999 → 16'h1000, with binary matching.
- Run with MAX_MS=9999 until 4×9999 cycles → elapsed_bcd=16'h9999, overflow=1, one done pulse, state HOLD; 20 further cycles → value unchanged.
- Simultaneous events:
  - stop on a tick cycle → the tick is counted.
  - start+stop in HOLD → a new run from 0.
  - start during RUN → ignored, count continues.
- clear mid-RUN at elapsed=12 → next cycle all zero, busy=0, no done pulse; rst mid-RUN → same result.
